// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, step size and buffer entry type for fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_STEP  = 4;

    // One buffered instruction with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : In-order synchronous FIFO of {pc, instr} with flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = XLEN + INSTR_W,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_entry,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // Storage carries no reset so it can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch
//  Description : RV64 fetch stage: PC, credit-limited imem requests, stale
//                response dropping and an in-order buffer towards decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC  = XLEN'(fetch_pkg::RESET_PC),
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               Redirect,
    input  logic [XLEN-1:0]    RedirectPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [XLEN-1:0]    InstrPC
);

    localparam int unsigned     c_CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int unsigned     c_ENTRY_W = XLEN + INSTR_W;
    localparam logic [XLEN-1:0] c_STEP    = XLEN'(PC_STEP);
    localparam logic [c_CNT_W:0] c_DEPTH  = (c_CNT_W + 1)'(BUF_DEPTH);

    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      r_rsp_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop_cnt;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_ENTRY_W-1:0] w_head;
    logic [XLEN-1:0]      w_redirect_pc;
    logic                 w_credit;
    logic                 w_req_fire;
    logic                 w_rsp_live;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_unused;

    assign w_redirect_pc = {RedirectPC[XLEN-1:2], 2'b00};
    assign w_unused      = &{1'b0, RedirectPC[1:0]};

    // Requests in flight plus buffered words never exceed the buffer size,
    // so every live response has a free slot waiting for it.
    assign w_credit       = ({1'b0, r_outstanding} + {1'b0, w_count}) < c_DEPTH;
    assign imem_req_valid = !reset && !Redirect && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_live = imem_rsp_valid && (r_outstanding != '0);
    assign w_push     = w_rsp_live && (r_drop_cnt == '0) && !Redirect;
    assign w_pop      = InstrValid && InstrReady && !Redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            case ({w_req_fire, w_rsp_live})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (Redirect) begin
                // Everything still in flight is stale, except a word landing now.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - {{(c_CNT_W-1){1'b0}}, w_rsp_live};
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + c_STEP;
                end
                if (w_rsp_live) begin
                    if (r_drop_cnt != '0) begin
                        r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
                    end else begin
                        r_rsp_pc <= r_rsp_pc + c_STEP;
                    end
                end
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (c_ENTRY_W),
        .CNT_W (c_CNT_W)
    ) u_buffer (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (Redirect),
        .i_entry ({r_rsp_pc, imem_rsp_data}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign InstrValid = (w_count != '0);
    assign Instr      = InstrValid ? w_head[INSTR_W-1:0] : '0;
    assign InstrPC    = InstrValid ? w_head[c_ENTRY_W-1:INSTR_W] : '0;

    a_rsp_without_req : assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch
//  Description : Randomized bench for fetch with an in-order imem model and a
//                sequential-PC reference stream for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch;

    localparam int          c_XLEN  = 64;
    localparam int          c_DEPTH = 2;
    localparam logic [63:0] c_RST   = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;

    fetch #(
        .XLEN      (c_XLEN),
        .RESET_PC  (c_RST),
        .BUF_DEPTH (c_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .Redirect       (Redirect),
        .RedirectPC     (RedirectPC),
        .InstrValid     (InstrValid),
        .InstrReady     (InstrReady),
        .Instr          (Instr),
        .InstrPC        (InstrPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    req_t        pending[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rsp_pct = 100, req_rdy_pct = 100, dec_rdy_pct = 100;
    int          lat_min = 1, lat_max = 1;
    int          acc_cnt = 0, pop_cnt = 0;
    logic [63:0] exp_pc, exp_req;
    logic        s_ivalid, s_reqv, s_rspv;
    logic [63:0] s_ipc, s_reqa;
    logic [31:0] s_instr;

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return (a[33:2] * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample mid-cycle, update the model.
    task automatic step(bit rst, bit redir, logic [63:0] rpc);
        @(negedge clk);
        reset      = rst;
        Redirect   = redir;
        RedirectPC = rpc;
        if (!rst && pending.size() > 0 && pending[0].due <= cyc &&
            int'($urandom_range(99)) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = int'($urandom_range(99)) < req_rdy_pct;
        InstrReady     = int'($urandom_range(99)) < dec_rdy_pct;
        #1;
        s_ivalid = InstrValid;
        s_ipc    = InstrPC;
        s_instr  = Instr;
        s_reqv   = imem_req_valid;
        s_reqa   = imem_req_addr;
        s_rspv   = imem_rsp_valid;
        if (rst) begin
            check("req_in_reset", {63'b0, imem_req_valid}, 64'd0);
            pending.delete();
            exp_pc  = c_RST;
            exp_req = c_RST;
            acc_cnt = 0;
        end else begin
            if (!InstrValid) begin
                check("idle_instr", {32'b0, Instr}, 64'd0);
                check("idle_pc", InstrPC, 64'd0);
            end
            if (redir) begin
                check("req_on_redirect", {63'b0, imem_req_valid}, 64'd0);
                exp_pc  = rpc & ~64'h3;
                exp_req = rpc & ~64'h3;
            end else begin
                if (InstrValid && InstrReady) begin
                    check("pop_pc", InstrPC, exp_pc);
                    check("pop_instr", {32'b0, Instr}, {32'b0, mem_word(exp_pc)});
                    exp_pc = exp_pc + 64'd4;
                    pop_cnt++;
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_req);
                    check("in_flight_limit", {63'b0, pending.size() < c_DEPTH}, 64'd1);
                    pending.push_back('{addr: imem_req_addr,
                                        due: cyc + int'($urandom_range(lat_max, lat_min))});
                    exp_req = exp_req + 64'd4;
                    acc_cnt++;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 64'd0);
        step(1'b1, 1'b0, 64'd0);
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // 1-cycle imem, decode always ready: first request at cycle 0, first word at cycle 2.
        do_reset();
        step(1'b0, 1'b0, 64'd0);
        check("t1_req_valid", {63'b0, s_reqv}, 64'd1);
        check("t1_req_addr", s_reqa, c_RST);
        step(1'b0, 1'b0, 64'd0);
        check("t1_c1_empty", {63'b0, s_ivalid}, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        check("t1_c2_valid", {63'b0, s_ivalid}, 64'd1);
        check("t1_c2_pc", s_ipc, c_RST);
        step(1'b0, 1'b0, 64'd0);
        check("t1_c3_pc", s_ipc, c_RST + 64'd4);
        repeat (8) step(1'b0, 1'b0, 64'd0);

        // Decode stalled: credits cap requests, head holds.
        do_reset();
        dec_rdy_pct = 0;
        repeat (10) step(1'b0, 1'b0, 64'd0);
        check("t2_req_count", acc_cnt, c_DEPTH);
        check("t2_hold_valid", {63'b0, s_ivalid}, 64'd1);
        check("t2_hold_pc", s_ipc, c_RST);
        dec_rdy_pct = 100;
        begin
            int p0 = pop_cnt;
            repeat (10) step(1'b0, 1'b0, 64'd0);
            check("t2_progress", {63'b0, (pop_cnt - p0) >= 3}, 64'd1);
        end

        // Redirect with two requests outstanding.
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        check("t3_two_out", pending.size(), 2);
        step(1'b0, 1'b1, 64'h2002);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                step(1'b0, 1'b0, 64'd0);
                if (s_ivalid) begin
                    seen = 1'b1;
                    check("t3_first_pc", s_ipc, 64'h2000);
                end
            end
            check("t3_seen", {63'b0, seen}, 64'd1);
        end
        lat_min = 1; lat_max = 1;

        // Redirect colliding with a response and a pop.
        do_reset();
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'h3000);
        check("t4_rsp_same", {63'b0, s_rspv}, 64'd1);
        check("t4_pop_same", {63'b0, s_ivalid}, 64'd1);
        step(1'b0, 1'b0, 64'd0);
        check("t4_flushed", {63'b0, s_ivalid}, 64'd0);
        repeat (8) step(1'b0, 1'b0, 64'd0);

        // imem not ready for 5 cycles.
        do_reset();
        req_rdy_pct = 0;
        repeat (5) step(1'b0, 1'b0, 64'd0);
        check("t5_no_accept", acc_cnt, 0);
        check("t5_addr_held", s_reqa, c_RST);
        req_rdy_pct = 100;
        repeat (10) step(1'b0, 1'b0, 64'd0);

        // Reset with a full buffer.
        do_reset();
        dec_rdy_pct = 0; lat_min = 2; lat_max = 2;
        repeat (8) step(1'b0, 1'b0, 64'd0);
        check("t6_full", {63'b0, s_ivalid}, 64'd1);
        step(1'b1, 1'b0, 64'd0);
        cyc = 0;
        step(1'b0, 1'b0, 64'd0);
        check("t6_valid", {63'b0, s_ivalid}, 64'd0);
        check("t6_instr", {32'b0, s_instr}, 64'd0);
        check("t6_restart", s_reqa, c_RST);
        dec_rdy_pct = 100;
        repeat (6) step(1'b0, 1'b0, 64'd0);

        // Random traffic with redirects and occasional resets.
        begin
            int p0 = pop_cnt;
            for (int i = 0; i < 4000; i++) begin
                if (i % 200 == 0) begin
                    rsp_pct     = int'($urandom_range(100, 40));
                    req_rdy_pct = int'($urandom_range(100, 40));
                    dec_rdy_pct = int'($urandom_range(100, 50));
                    lat_min     = int'($urandom_range(2, 1));
                    lat_max     = lat_min + int'($urandom_range(3, 0));
                end
                if ($urandom_range(999) < 3)
                    step(1'b1, 1'b0, 64'd0);
                else if ($urandom_range(99) < 3)
                    step(1'b0, 1'b1, {$urandom, $urandom});
                else
                    step(1'b0, 1'b0, 64'd0);
            end
            check("rand_progress", {63'b0, (pop_cnt - p0) > 300}, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
